control_sequencer: RTL and testbench

// - Microcoded control unit for the 8-bit bus computer: step counter plus microcode decode driving all 16 control lines.
// - Replaces the external fixed 5-step counter with a parametrised sequencer.
// - Adds variable-length instructions (early step wrap), flag-conditional jumps, a run/pause gate and a sticky halt.
// - Sits beside the instruction register; outputs feed the register, ALU, MAR, RAM and PC enables.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/control_sequencer_microcode_rom.sv | 85 ++++++++
 rtl/control_sequencer.sv | 113 +++++++++++
 tb/tb_control_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus computer control path.
// - opcode_e : 4-bit opcode encodings held in IR[N-1:A].
// - ctrl_t   : the 16 active-high control lines, MSB (hlt) to LSB (fi).
// - CTRL_NONE: all-zero control word.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_LDA = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_STA = 4'b0100,
    OP_LDI = 4'b0101,
    OP_JMP = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// microcode_rom: combinational decode of {opcode, step, cf, zf} into a
// control word.
// Ports:
//   opcode  in  OPW  instruction opcode
//   step    in  SW   current microstep
//   cf, zf  in  1    registered ALU flags (used by JC/JZ at T2)
//   ctrl    out 16   decoded control word (ctrl_t)
module microcode_rom
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4,
  parameter int unsigned SW  = 3
) (
  input  logic [OPW-1:0] opcode,
  input  logic [SW-1:0]  step,
  input  logic           cf,
  input  logic           zf,
  output ctrl_t          ctrl
);

  opcode_e op;
  logic    t2;
  logic    t3;
  logic    t4;

  always_comb begin
    op = opcode_e'(opcode);
    t2 = (step == SW'(2));
    t3 = (step == SW'(3));
    t4 = (step == SW'(4));
  end

  always_comb begin
    ctrl = CTRL_NONE;
    if (step == '0) begin
      ctrl.co = 1'b1;
      ctrl.mi = 1'b1;
    end else if (step == SW'(1)) begin
      ctrl.ro = 1'b1;
      ctrl.ii = 1'b1;
      ctrl.ce = 1'b1;
    end else begin
      case (op)
        OP_LDA: begin
          if (t2) begin ctrl.io = 1'b1; ctrl.mi = 1'b1; end
          if (t3) begin ctrl.ro = 1'b1; ctrl.ai = 1'b1; end
        end
        OP_ADD, OP_SUB: begin
          if (t2) begin ctrl.io = 1'b1; ctrl.mi = 1'b1; end
          if (t3) begin ctrl.ro = 1'b1; ctrl.bi = 1'b1; end
          if (t4) begin
            ctrl.eo = 1'b1;
            ctrl.ai = 1'b1;
            ctrl.fi = 1'b1;
            ctrl.su = (op == OP_SUB);
          end
        end
        OP_STA: begin
          if (t2) begin ctrl.io = 1'b1; ctrl.mi = 1'b1; end
          if (t3) begin ctrl.ao = 1'b1; ctrl.ri = 1'b1; end
        end
        OP_LDI: begin
          if (t2) begin ctrl.io = 1'b1; ctrl.ai = 1'b1; end
        end
        OP_JMP: begin
          if (t2) begin ctrl.io = 1'b1; ctrl.j = 1'b1; end
        end
        OP_JC: begin
          if (t2 && cf) begin ctrl.io = 1'b1; ctrl.j = 1'b1; end
        end
        OP_JZ: begin
          if (t2 && zf) begin ctrl.io = 1'b1; ctrl.j = 1'b1; end
        end
        OP_OUT: begin
          if (t2) begin ctrl.ao = 1'b1; ctrl.oi = 1'b1; end
        end
        OP_HLT: begin
          if (t2) ctrl.hlt = 1'b1;
        end
        default: ctrl = CTRL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus computer.
// Step counter with early wrap on an all-zero word, sticky halt, run gate.
// Ports:
//   clk           in   1   rising-edge clock
//   clr           in   1   synchronous active-high reset (forces outputs 0)
//   run           in   1   1 = advance, 0 = hold step with outputs 0
//   irval         in   N   instruction register; opcode = irval[N-1:A]
//   cf, zf        in   1   registered ALU flags
//   hlt..fi       out  1   control lines, active-high
//   step          out  SW  current microstep
//   halted        out  1   sticky halt state
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned A     = 4,
  parameter int unsigned OPW   = N - A,
  parameter int unsigned STEPS = 8,
  parameter int unsigned SW    = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          run,
  input  logic [N-1:0]  irval,
  input  logic          cf,
  input  logic          zf,
  output logic          hlt,
  output logic          mi,
  output logic          ri,
  output logic          ro,
  output logic          io,
  output logic          ii,
  output logic          ai,
  output logic          ao,
  output logic          eo,
  output logic          su,
  output logic          bi,
  output logic          oi,
  output logic          ce,
  output logic          co,
  output logic          j,
  output logic          fi,
  output logic [SW-1:0] step,
  output logic          halted
);

  logic [SW-1:0] step_q;
  logic [SW-1:0] step_d;
  logic          halted_q;
  logic          halted_d;
  ctrl_t         rom_word;
  ctrl_t         ctrl_out;
  logic          unused_operand;

  always_comb unused_operand = ^irval[A-1:0];

  microcode_rom #(
    .OPW (OPW),
    .SW  (SW)
  ) u_rom (
    .opcode (irval[N-1:A]),
    .step   (step_q),
    .cf     (cf),
    .zf     (zf),
    .ctrl   (rom_word)
  );

  // The halting edge keeps step where it is, so a halted machine
  // reports the step of its HLT word.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      if (rom_word.hlt) begin
        halted_d = 1'b1;
      end else if ((step_q == SW'(STEPS - 1)) ||
                   ((step_q >= SW'(2)) && (rom_word == CTRL_NONE))) begin
        step_d = '0;
      end else begin
        step_d = step_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Priority: clr, then run gate, then halt forcing, then microcode.
  always_comb begin
    ctrl_out = CTRL_NONE;
    if (!clr && run) begin
      if (halted_q) begin
        ctrl_out.hlt = 1'b1;
      end else begin
        ctrl_out = rom_word;
      end
    end
  end

  always_comb begin
    {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi} = ctrl_out;
    step   = step_q;
    halted = halted_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [15:0] W_ZERO  = 16'h0000;
  localparam logic [15:0] W_T0    = 16'h4004; // co,mi
  localparam logic [15:0] W_T1    = 16'h1408; // ro,ii,ce
  localparam logic [15:0] W_IOMI  = 16'h4800; // io,mi
  localparam logic [15:0] W_ROAI  = 16'h1200; // ro,ai
  localparam logic [15:0] W_ROBI  = 16'h1020; // ro,bi
  localparam logic [15:0] W_ADD4  = 16'h0281; // eo,ai,fi
  localparam logic [15:0] W_SUB4  = 16'h02C1; // eo,ai,fi,su
  localparam logic [15:0] W_IOJ   = 16'h0802; // io,j
  localparam logic [15:0] W_HLT   = 16'h8000; // hlt

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic [7:0] irval;
  logic       cf;
  logic       zf;
  logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
  logic [2:0] step;
  logic       halted;
  logic [15:0] word;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  control_sequencer #(
    .N     (8),
    .A     (4),
    .STEPS (8)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .irval  (irval),
    .cf     (cf),
    .zf     (zf),
    .hlt    (hlt),
    .mi     (mi),
    .ri     (ri),
    .ro     (ro),
    .io     (io),
    .ii     (ii),
    .ai     (ai),
    .ao     (ao),
    .eo     (eo),
    .su     (su),
    .bi     (bi),
    .oi     (oi),
    .ce     (ce),
    .co     (co),
    .j      (j),
    .fi     (fi),
    .step   (step),
    .halted (halted)
  );

  always_comb word = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sw(input string tag, input logic [2:0] s, input logic [15:0] w);
    check({tag, ".step"}, 32'(step), 32'(s));
    check({tag, ".word"}, 32'(word), 32'(w));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; run = 1'b1; irval = 8'h00; cf = 1'b0; zf = 1'b0;
    #1;
    check("clr_word_async", 32'(word), 32'(W_ZERO));
    tick();
    expect_sw("reset", 3'd0, W_ZERO);
    check("reset.halted", 32'(halted), 32'd0);
    clr = 1'b0;
    #1;
    expect_sw("release", 3'd0, W_T0);

    // LDA
    irval = 8'h1E;
    tick(); expect_sw("lda.t1", 3'd1, W_T1);
    tick(); expect_sw("lda.t2", 3'd2, W_IOMI);
    tick(); expect_sw("lda.t3", 3'd3, W_ROAI);
    tick(); expect_sw("lda.t4", 3'd4, W_ZERO);
    tick(); expect_sw("lda.wrap", 3'd0, W_T0);

    // JC taken
    irval = 8'h73; cf = 1'b1;
    tick(); tick(); expect_sw("jc1.t2", 3'd2, W_IOJ);
    tick(); expect_sw("jc1.t3", 3'd3, W_ZERO);
    tick(); expect_sw("jc1.wrap", 3'd0, W_T0);

    // JC not taken
    cf = 1'b0;
    tick(); tick(); expect_sw("jc0.t2", 3'd2, W_ZERO);
    tick(); expect_sw("jc0.wrap", 3'd0, W_T0);

    // JZ taken, with cf irrelevant
    irval = 8'h85; zf = 1'b1; cf = 1'b1;
    tick(); tick(); expect_sw("jz1.t2", 3'd2, W_IOJ);
    tick(); tick(); expect_sw("jz1.wrap", 3'd0, W_T0);
    zf = 1'b0; cf = 1'b0;

    // SUB
    irval = 8'h3F;
    tick(); tick(); expect_sw("sub.t2", 3'd2, W_IOMI);
    tick(); expect_sw("sub.t3", 3'd3, W_ROBI);
    tick(); expect_sw("sub.t4", 3'd4, W_SUB4);
    tick(); expect_sw("sub.t5", 3'd5, W_ZERO);
    tick(); expect_sw("sub.wrap", 3'd0, W_T0);

    // Undefined opcode behaves as NOP (3 cycles)
    irval = 8'hA0;
    tick(); tick(); expect_sw("nop.t2", 3'd2, W_ZERO);
    tick(); expect_sw("nop.wrap", 3'd0, W_T0);

    // HLT
    irval = 8'hF0;
    tick(); tick(); expect_sw("hlt.t2", 3'd2, W_HLT);
    check("hlt.t2.halted", 32'(halted), 32'd0);
    tick();
    check("hlt.set", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_sw("hlt.hold", 3'd2, W_HLT);
    end
    run = 1'b0;
    #1; expect_sw("hlt.norun", 3'd2, W_ZERO);
    tick(); expect_sw("hlt.norun_edge", 3'd2, W_ZERO);
    run = 1'b1;
    clr = 1'b1;
    #1; check("hlt.clr_word", 32'(word), 32'(W_ZERO));
    tick();
    check("hlt.clr_halted", 32'(halted), 32'd0);
    clr = 1'b0;
    #1; expect_sw("hlt.clr_exit", 3'd0, W_T0);

    // ADD with pause at T3
    irval = 8'h2F;
    tick(); tick(); tick(); expect_sw("add.t3", 3'd3, W_ROBI);
    run = 1'b0;
    #1; expect_sw("pause.now", 3'd3, W_ZERO);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_sw("pause.hold", 3'd3, W_ZERO);
    end
    run = 1'b1;
    #1; expect_sw("resume.t3", 3'd3, W_ROBI);
    tick(); expect_sw("resume.t4", 3'd4, W_ADD4);
    tick(); expect_sw("resume.t5", 3'd5, W_ZERO);
    tick(); expect_sw("resume.wrap", 3'd0, W_T0);

    // Abort ADD at T3 with clr
    tick(); tick(); tick(); expect_sw("abort.t3", 3'd3, W_ROBI);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1; expect_sw("abort.restart", 3'd0, W_T0);
    tick(); expect_sw("abort.t1", 3'd1, W_T1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
